iob_eth_tx_feeder: RTL and testbench



---
 rtl/iob_eth_tx_feeder.sv | 228 ++++++++++++++++++++++
 tb/tb_iob_eth_tx_feeder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_tx_feeder.sv
// -----------------------------------------------------------------------------
// iob_eth_tx_feeder
//
// Hardware frame source for the Ethernet core's transmit path. Frames arrive
// as a valid/ready byte stream. The feeder drives the core's CPU-side register
// port as a bus master:
//   1. poll the status register until tx_ready (data_in[0]) is high;
//   2. write each byte into the TX buffer window at {1'b1, idx[10:0]};
//   3. write the byte count to the TX byte-count register;
//   4. write 1 to the control register to start transmission;
//   5. poll status until tx_ready drops (or a timeout), then start over.
// Frames longer than MAX_BYTES are flagged and drained without being sent.
//
// Configuration macro:
//   IOB_ETH_FEEDER_PAD_EN - when defined, frames shorter than 60 bytes are
//                           zero-padded to 60 bytes before being sent.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   s_data/s_valid/s_last byte stream in; s_last marks the final frame byte
//   s_ready               byte stream ready (LOAD and DROP only)
//   sel, we, addr         registered core register-port controls
//   data_out              registered write data to the core
//   data_in               read data from the core; bit 0 is tx_ready
//   busy                  high in every state except POLL
//   err_oversize          one-cycle pulse when a frame exceeds MAX_BYTES
//   frame_cnt             frames sent, wraps modulo 2^16
// -----------------------------------------------------------------------------

// Fallback register map, used only when iob_eth_defs.vh was not read first.
`ifndef ETH_STATUS
  `define ETH_STATUS 12'd1
`endif
`ifndef ETH_CONTROL
  `define ETH_CONTROL 12'd2
`endif
`ifndef ETH_TX_NBYTES
  `define ETH_TX_NBYTES 12'd6
`endif

module iob_eth_tx_feeder #(
  parameter int                ADDR_W       = 12,
  parameter logic [ADDR_W-1:0] STATUS_ADDR  = ADDR_W'(`ETH_STATUS),
  parameter logic [ADDR_W-1:0] CONTROL_ADDR = ADDR_W'(`ETH_CONTROL),
  parameter logic [ADDR_W-1:0] NBYTES_ADDR  = ADDR_W'(`ETH_TX_NBYTES),
  parameter int                MAX_BYTES    = 1518,
  parameter int                BUSY_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              sel,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       data_out,
  input  logic [31:0]       data_in,
  output logic              busy,
  output logic              err_oversize,
  output logic [15:0]       frame_cnt
);

  localparam int TMO_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
`ifdef IOB_ETH_FEEDER_PAD_EN
  localparam int MIN_LEN = 60;
`endif

  typedef enum logic [2:0] {
    POLL,
    LOAD,
    DROP,
    NBYTES,
    SEND,
    WAIT_BUSY
`ifdef IOB_ETH_FEEDER_PAD_EN
    , PAD
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [10:0]         idx_q, idx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                sel_d, we_d, err_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         data_d;
  logic [15:0]         cnt_d;

  // A status read is on the bus this cycle; the core answers combinationally,
  // so data_in[0] is only meaningful while this is high.
  logic read_on_bus;
  logic tx_ready;
  assign read_on_bus = sel & ~we;
  assign tx_ready    = data_in[0];

  // Only tx_ready is defined in the status word.
  logic unused_data_in;
  assign unused_data_in = ^data_in[31:1];

  assign busy    = (state_q != POLL);
  assign s_ready = (state_q == LOAD) || (state_q == DROP);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    sel_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    err_d   = 1'b0;
    cnt_d   = frame_cnt;

    case (state_q)
      POLL: begin
        if (read_on_bus && tx_ready) begin
          state_d = LOAD;
          idx_d   = '0;
        end else begin
          sel_d  = 1'b1;
          addr_d = STATUS_ADDR;
        end
      end

      LOAD: begin
        if (s_valid) begin
          sel_d  = 1'b1;
          we_d   = 1'b1;
          addr_d = ADDR_W'({1'b1, idx_q});
          data_d = {24'b0, s_data};
          idx_d  = idx_q + 11'd1;
          if (s_last) begin
`ifdef IOB_ETH_FEEDER_PAD_EN
            state_d = (idx_q < 11'(MIN_LEN - 1)) ? PAD : NBYTES;
`else
            state_d = NBYTES;
`endif
          end else if (idx_q == 11'(MAX_BYTES - 1)) begin
            // The buffer is full and more bytes follow: abandon the frame.
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
      end

      DROP: begin
        if (s_valid && s_last) begin
          state_d = POLL;
          sel_d   = 1'b1;
          addr_d  = STATUS_ADDR;
        end
      end

`ifdef IOB_ETH_FEEDER_PAD_EN
      PAD: begin
        sel_d  = 1'b1;
        we_d   = 1'b1;
        addr_d = ADDR_W'({1'b1, idx_q});
        idx_d  = idx_q + 11'd1;
        if (idx_q == 11'(MIN_LEN - 1)) state_d = NBYTES;
      end
`endif

      NBYTES: begin
        // idx has advanced past the last written byte, so it is the count.
        sel_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = NBYTES_ADDR;
        data_d  = {21'b0, idx_q};
        state_d = SEND;
      end

      SEND: begin
        sel_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = CONTROL_ADDR;
        data_d  = 32'h1;
        cnt_d   = frame_cnt + 16'd1;
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        // tx_ready crosses clock domains inside the core, so it can stay
        // high for a few cycles after the send command.
        sel_d  = 1'b1;
        addr_d = STATUS_ADDR;
        if ((read_on_bus && !tx_ready) || tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
          state_d = POLL;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: state_d = POLL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= POLL;
      idx_q        <= '0;
      tmo_q        <= '0;
      sel          <= 1'b0;
      we           <= 1'b0;
      addr         <= '0;
      data_out     <= '0;
      err_oversize <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      sel          <= sel_d;
      we           <= we_d;
      addr         <= addr_d;
      data_out     <= data_d;
      err_oversize <= err_d;
      frame_cnt    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_iob_eth_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_iob_eth_tx_feeder
//
// Directed bench for iob_eth_tx_feeder. A frame-level model turns each frame
// into the list of register writes the core must receive (buffer bytes,
// optional padding, byte count, send command); a monitor pops that list on
// every bus write and checks every read targets the status register.
// Hand-computed literals pin latencies, counts and reset values.
// -----------------------------------------------------------------------------
module tb_iob_eth_tx_feeder;

  localparam int          ADDR_W    = 12;
  localparam logic [11:0] STATUS_A  = 12'h001;
  localparam logic [11:0] CONTROL_A = 12'h002;
  localparam logic [11:0] NBYTES_A  = 12'h006;
  localparam int          MAX       = 1518;
  localparam int          TMO       = 64;
`ifdef IOB_ETH_FEEDER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int NB_10 = PAD_EN ? 60 : 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        sel;
  logic        we;
  logic [11:0] addr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        busy;
  logic        err_oversize;
  logic [15:0] frame_cnt;
  logic        tx_ready;

  // Upper status bits carry junk that the feeder must ignore.
  assign data_in = {31'h2AAA_AAAA, tx_ready};

  always #5 clk = ~clk;

  iob_eth_tx_feeder #(
    .ADDR_W      (ADDR_W),
    .STATUS_ADDR (STATUS_A),
    .CONTROL_ADDR(CONTROL_A),
    .NBYTES_ADDR (NBYTES_A),
    .MAX_BYTES   (MAX),
    .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .sel         (sel),
    .we          (we),
    .addr        (addr),
    .data_out    (data_out),
    .data_in     (data_in),
    .busy        (busy),
    .err_oversize(err_oversize),
    .frame_cnt   (frame_cnt)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         cur;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_nbytes = '0;
  int          err_seen = 0;
  logic [11:0] err_addr = '0;
  bit          hung = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_val(input int f, input int i);
    return 8'((f * 29 + i * 7) ^ (i >> 4));
  endfunction

  // Frame-level model: the writes the core must see for one frame.
  task automatic model_frame(input int f, input int len);
    int n;
    int cnt;
    n = (len > MAX) ? MAX : len;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{a: 12'h800 + 12'(i), d: {24'b0, byte_val(f, i)}});
    if (len > MAX) return;
    cnt = len;
    if (PAD_EN && len < 60) begin
      for (int i = len; i < 60; i++) exp_q.push_back('{a: 12'h800 + 12'(i), d: 32'h0});
      cnt = 60;
    end
    exp_q.push_back('{a: NBYTES_A, d: 32'(cnt)});
    exp_q.push_back('{a: CONTROL_A, d: 32'h1});
  endtask

  // Monitor: every write must be the next expected one; reads hit status.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sel && we) begin
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else                  cur = '{a: 12'hFFF, d: 32'hFFFF_FFFF};
        check("write_addr", 32'(addr), 32'(cur.a));
        check("write_data", data_out, cur.d);
        if (addr == NBYTES_A) last_nbytes = data_out;
      end else if (sel) begin
        check("read_addr", 32'(addr), 32'(STATUS_A));
      end
      if (err_oversize) begin
        err_seen++;
        err_addr = addr;
      end
    end
  end

  // Called just after a negedge; returns just after the negedge that follows
  // the accepting posedge.
  task automatic push_byte(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    if (hung) return;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      hung = 1'b1;
      check("s_ready_wait", 32'(s_ready), 32'd1);
    end else begin
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int f, input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && (i % 3 == 1)) repeat ((i % 5) % 3 + 1) @(negedge clk);
      push_byte(byte_val(f, i), i == len - 1);
    end
  endtask

  task automatic wait_send();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (sel && we && addr == CONTROL_A) found = 1'b1;
      else @(negedge clk);
    end
    check("send_seen", 32'(found), 32'd1);
  endtask

  // Core behaviour after a send: tx_ready drops briefly, then returns.
  task automatic release_tx();
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    tx_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst_n    = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_oversize), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // First poll read in the first cycle after release, LOAD one cycle later.
    rst_n = 1'b1;
    @(negedge clk);
    check("first_poll_sel", 32'(sel), 32'd1);
    check("first_poll_we", 32'(we), 32'd0);
    check("first_poll_addr", 32'(addr), 32'(STATUS_A));
    check("first_poll_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("load_s_ready", 32'(s_ready), 32'd1);
    check("load_busy", 32'(busy), 32'd1);

    // 64-byte frame at full rate.
    model_frame(1, 64);
    send_frame(1, 64, 1'b0);
    wait_send();
    check("f64_frame_cnt", 32'(frame_cnt), 32'd1);
    check("f64_nbytes", last_nbytes, 32'd64);

    // tx_ready held low for 100 cycles: polls only, no stream handshake.
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || busy !== 1'b0 || sel !== 1'b1 || we !== 1'b0) bad++;
    end
    check("hold_bad_cycles", 32'(bad), 32'd0);
    tx_ready = 1'b1;
    check("hold_s_ready_before", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("hold_s_ready_after", 32'(s_ready), 32'd1);

    // 10-byte frame (padded to 60 when padding is built in).
    model_frame(2, 10);
    send_frame(2, 10, 1'b0);
    wait_send();
    check("f10_frame_cnt", 32'(frame_cnt), 32'd2);
    check("f10_nbytes", last_nbytes, 32'(NB_10));
    release_tx();

    // 1600-byte frame: oversize pulse with the write of byte 1518, no send.
    model_frame(3, 1600);
    send_frame(3, 1600, 1'b0);
    repeat (10) @(negedge clk);
    check("over_frame_cnt", 32'(frame_cnt), 32'd2);
    check("over_err_count", 32'(err_seen), 32'd1);
    check("over_err_addr", 32'(err_addr), 32'h0000_0DED);

    // 100-byte frame with stream gaps.
    model_frame(4, 100);
    send_frame(4, 100, 1'b1);
    wait_send();
    check("gap_frame_cnt", 32'(frame_cnt), 32'd3);
    check("gap_nbytes", last_nbytes, 32'd100);
    release_tx();

    // Reset after byte 20: bytes already written, then nothing more.
    for (int i = 0; i < 20; i++)
      exp_q.push_back('{a: 12'h800 + 12'(i), d: {24'b0, byte_val(5, i)}});
    for (int i = 0; i < 20; i++) push_byte(byte_val(5, i), 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(sel), 32'd0);
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_addr", 32'(addr), 32'd0);
    check("mid_rst_data_out", data_out, 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_drained", 32'(exp_q.size()), 32'd0);

    // A fresh frame after the abandoned one goes through normally.
    model_frame(6, 5);
    send_frame(6, 5, 1'b0);
    wait_send();
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);
    release_tx();

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
